// File: rtl/regfile_ctrl.sv
// regfile_ctrl: round-robin write-port arbiter and clear sequencer for the register file
// Optional build macro REGFILE_CTRL_PRIO0_EN: requester 0 wins whenever eligible, round-robin among the rest.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req[NREQ]           level write requests, held until granted
//   addr_bus, data_bus  per-requester target register / write data (slice i belongs to requester i)
//   clr_all             one-cycle pulse starting a clear sweep
//   gnt[NREQ]           one-hot grant pulse
//   busy                high while the clear sweep runs
//   rf_s, rf_e, rf_d    register file write select / enable / data
//   rf_clr[2**W1]       per-register clear strobes
module regfile_ctrl #(
  parameter int W1 = 2,
  parameter int W2 = 8,
  parameter int NREQ = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*W1-1:0]   addr_bus,
  input  logic [NREQ*W2-1:0]   data_bus,
  input  logic                 clr_all,
  output logic [NREQ-1:0]      gnt,
  output logic                 busy,
  output logic [W1-1:0]        rf_s,
  output logic                 rf_e,
  output logic [W2-1:0]        rf_d,
  output logic [2**W1-1:0]     rf_clr
);
  localparam int NR = 2**W1;
  localparam int PW = $clog2(NREQ);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state;
  logic [PW-1:0] ptr, k, nxt_ptr;
  logic [W1-1:0] cnt;
  logic [NREQ-1:0] elig, rr_mask;
  logic found, adv;
  // gnt still holds last cycle's grant, which is exactly the requester barred from a repeat
  always_comb begin
    elig = req & ~gnt;
`ifdef REGFILE_CTRL_PRIO0_EN
    rr_mask = elig & ~NREQ'(1);
`else
    rr_mask = elig;
`endif
    found = 1'b0;
    k = '0;
    for (int j = 0; j < NREQ; j++)
      if (!found && rr_mask[(int'(ptr) + j) % NREQ]) begin
        found = 1'b1;
        k = PW'((int'(ptr) + j) % NREQ);
      end
`ifdef REGFILE_CTRL_PRIO0_EN
    if (elig[0]) begin
      found = 1'b1;
      k = '0;
    end
    adv = found && k != '0;
`else
    adv = found;
`endif
    nxt_ptr = (k == PW'(NREQ - 1)) ? '0 : k + PW'(1);
  end
  // The last sweep edge also arbitrates, so requests held through the sweep are granted as busy drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      cnt <= '0;
      gnt <= '0;
      busy <= 1'b0;
      rf_s <= '0;
      rf_e <= 1'b0;
      rf_d <= '0;
      rf_clr <= '0;
    end else begin
      gnt <= '0;
      rf_e <= 1'b0;
      rf_clr <= '0;
      if (state == IDLE && clr_all) begin
        state <= CLEAR;
        busy <= 1'b1;
        cnt <= '0;
        rf_clr <= NR'(1);
      end else if (state == CLEAR && cnt != W1'(NR - 1)) begin
        cnt <= cnt + W1'(1);
        rf_clr <= NR'(1) << (cnt + W1'(1));
      end else begin
        state <= IDLE;
        busy <= 1'b0;
        cnt <= '0;
        if (found) begin
          gnt <= NREQ'(1) << k;
          rf_e <= 1'b1;
          rf_s <= addr_bus[k*W1 +: W1];
          rf_d <= data_bus[k*W2 +: W2];
          if (adv) ptr <= nxt_ptr;
        end
      end
    end
  end
endmodule

// File: tb/tb_regfile_ctrl.sv
// tb_regfile_ctrl: scoreboard bench for regfile_ctrl with directed stimulus
module tb_regfile_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] req;
  logic [7:0] addr_bus;
  logic [31:0] data_bus;
  logic clr_all;
  logic [3:0] gnt;
  logic busy;
  logic [1:0] rf_s;
  logic rf_e;
  logic [7:0] rf_d;
  logic [3:0] rf_clr;
  typedef struct {
    int c;
    logic [3:0] g;
    logic e;
    logic [1:0] s;
    logic [7:0] d;
    logic b;
    logic [3:0] clr;
  } exp_t;
  exp_t q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [3:0] seq1 [5];
  logic [3:0] seq7 [4];
  regfile_ctrl #(.W1(2), .W2(8), .NREQ(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .addr_bus(addr_bus), .data_bus(data_bus),
    .clr_all(clr_all), .gnt(gnt), .busy(busy), .rf_s(rf_s), .rf_e(rf_e), .rf_d(rf_d),
    .rf_clr(rf_clr)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic push(input int dc, input logic [3:0] g, input logic b, input logic [3:0] clr);
    exp_t e;
    e.c = cyc + dc;
    e.g = g;
    e.e = (g != 4'b0);
    e.b = b;
    e.clr = clr;
    e.s = 2'd0;
    e.d = 8'd0;
    for (int i = 0; i < 4; i++)
      if (g[i]) begin
        e.s = 2'(i);
        e.d = data_bus[i*8 +: 8];
      end
    q.push_back(e);
  endtask
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %h, want %h", n, a, x);
    end
  endtask
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].c < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed output: expected at cycle %0d gnt=%b clr=%b", q[0].c, q[0].g, q[0].clr);
      void'(q.pop_front());
    end
    if (rst_n && (gnt != 4'b0 || rf_e || busy || rf_clr != 4'b0)) begin
      checks++;
      if (q.size() == 0 || q[0].c != cyc) begin
        errors++;
        $display("FAIL unexpected output at cycle %0d: gnt=%b rf_e=%b busy=%b rf_clr=%b", cyc, gnt, rf_e, busy, rf_clr);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (gnt !== e.g || rf_e !== e.e || busy !== e.b || rf_clr !== e.clr ||
            (e.e && (rf_s !== e.s || rf_d !== e.d))) begin
          errors++;
          $display("FAIL output at cycle %0d: got gnt=%b rf_e=%b rf_s=%0d rf_d=%h busy=%b rf_clr=%b, want gnt=%b rf_e=%b rf_s=%0d rf_d=%h busy=%b rf_clr=%b",
                   cyc, gnt, rf_e, rf_s, rf_d, busy, rf_clr, e.g, e.e, e.s, e.d, e.b, e.clr);
        end
      end
    end
  end
  initial begin
`ifdef REGFILE_CTRL_PRIO0_EN
    seq1 = '{4'b0001, 4'b0010, 4'b0001, 4'b0100, 4'b0001};
    seq7 = '{4'b0001, 4'b0010, 4'b0001, 4'b0100};
`else
    seq1 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    seq7 = '{4'b0001, 4'b0010, 4'b0100, 4'b0001};
`endif
    rst_n = 1'b0;
    req = 4'b1111;
    clr_all = 1'b0;
    addr_bus = 8'b11_10_01_00;
    data_bus = 32'h3CA55A11;
    repeat (2) @(negedge clk);
    chk("reset gnt", 32'(gnt), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset rf_s", 32'(rf_s), 0);
    chk("reset rf_e", 32'(rf_e), 0);
    chk("reset rf_d", 32'(rf_d), 0);
    chk("reset rf_clr", 32'(rf_clr), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) push(i + 1, seq1[i], 1'b0, 4'b0);
    repeat (5) @(negedge clk);
    req = 4'b0;
    repeat (2) @(negedge clk);
    req = 4'b0010;
    push(1, 4'b0010, 1'b0, 4'b0);
    push(3, 4'b0010, 1'b0, 4'b0);
    push(5, 4'b0010, 1'b0, 4'b0);
    repeat (6) @(negedge clk);
    req = 4'b0;
    repeat (2) @(negedge clk);
    clr_all = 1'b1;
    req = 4'b1000;
    for (int i = 0; i < 4; i++) push(i + 1, 4'b0, 1'b1, 4'b1 << i);
    push(5, 4'b1000, 1'b0, 4'b0);
    @(negedge clk);
    clr_all = 1'b0;
    repeat (4) @(negedge clk);
    req = 4'b0;
    repeat (2) @(negedge clk);
    clr_all = 1'b1;
    for (int i = 0; i < 4; i++) push(i + 1, 4'b0, 1'b1, 4'b1 << i);
    @(negedge clk);
    clr_all = 1'b0;
    @(negedge clk);
    clr_all = 1'b1;
    @(negedge clk);
    clr_all = 1'b0;
    repeat (5) @(negedge clk);
    req = 4'b0010;
    push(1, 4'b0010, 1'b0, 4'b0);
    @(negedge clk);
    req = 4'b0;
    repeat (2) @(negedge clk);
    clr_all = 1'b1;
    push(1, 4'b0, 1'b1, 4'b0001);
    push(2, 4'b0, 1'b1, 4'b0010);
    @(negedge clk);
    clr_all = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset busy", 32'(busy), 0);
    chk("async reset rf_clr", 32'(rf_clr), 0);
    @(negedge clk);
    req = 4'b0110;
    rst_n = 1'b1;
    push(1, 4'b0010, 1'b0, 4'b0);
    push(2, 4'b0100, 1'b0, 4'b0);
    repeat (2) @(negedge clk);
    req = 4'b0;
    repeat (2) @(negedge clk);
    req = 4'b0101;
    push(1, 4'b0001, 1'b0, 4'b0);
    push(2, 4'b0100, 1'b0, 4'b0);
    push(3, 4'b0001, 1'b0, 4'b0);
    push(4, 4'b0100, 1'b0, 4'b0);
    repeat (4) @(negedge clk);
    req = 4'b0;
    repeat (2) @(negedge clk);
    req = 4'b0111;
    for (int i = 0; i < 4; i++) push(i + 1, seq7[i], 1'b0, 4'b0);
    repeat (4) @(negedge clk);
    req = 4'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard drained", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
